// File: rtl/dbg_guv_pkg.sv
// Shared constants, state type and helpers for the debug command path.
package dbg_guv_pkg;

    localparam int unsigned CMD_WIDTH     = 32;
    localparam int unsigned BYTES_PER_CMD = 4;
    localparam int unsigned ERR_CNT_W     = 8;

    typedef enum logic {
        ASSEMBLE = 1'b0,
        DISCARD  = 1'b1
    } asm_state_t;

    function automatic logic [ERR_CNT_W-1:0] err_inc(input logic [ERR_CNT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/dbg_cmd_fifo.sv
// Synchronous command FIFO; the head entry drives the output data directly.
import dbg_guv_pkg::*;

module dbg_cmd_fifo #(
    parameter int unsigned WIDTH = CMD_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    output logic                       full_o,
    input  logic                       pop_i,
    output logic                       empty_o,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the registered level, so a same-cycle pop never makes room.
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/dbg_cmd_assembler.sv
// Assembles LSB-first host bytes into 32-bit debug commands with TLAST framing checks.
// Optional inter-byte timeout enabled by defining DBG_CMD_TIMEOUT_EN.
import dbg_guv_pkg::*;

module dbg_cmd_assembler #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    byte_in_TDATA,
    input  logic                          byte_in_TVALID,
    input  logic                          byte_in_TLAST,
    output logic                          byte_in_TREADY,
    output logic [31:0]                   cmd_out_TDATA,
    output logic                          cmd_out_TVALID,
    input  logic                          cmd_out_TREADY,
    output logic [7:0]                    err_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned IDX_W   = $clog2(BYTES_PER_CMD);
    localparam int unsigned SHIFT_W = CMD_WIDTH - 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_CMD - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    asm_state_t           state_q;
    logic [IDX_W-1:0]     byte_idx_q;
    logic [SHIFT_W-1:0]   shift_q;
    logic [ERR_CNT_W-1:0] err_q;
    logic                 rdy_en_q;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 at_last;
    logic                 accept;
    logic                 push;
    logic                 timeout;

    // The final byte is held off while the FIFO has no room for the finished word.
    assign at_last        = (state_q == ASSEMBLE) && (byte_idx_q == LAST_IDX);
    assign byte_in_TREADY = rdy_en_q && !(at_last && fifo_full);
    assign accept         = byte_in_TVALID && byte_in_TREADY;
    assign push           = accept && at_last && byte_in_TLAST;
    assign cmd_out_TVALID = !fifo_empty;
    assign err_count      = err_q;

`ifdef DBG_CMD_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer_q;
    logic             counting;

    assign counting = (state_q == ASSEMBLE) && (byte_idx_q != '0) && !accept;
    assign timeout  = counting && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else if (!counting || timeout) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ASSEMBLE;
            byte_idx_q <= '0;
            shift_q    <= '0;
            err_q      <= '0;
            rdy_en_q   <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (accept) begin
                case (state_q)
                    ASSEMBLE: begin
                        if (byte_idx_q != LAST_IDX) begin
                            shift_q[8*byte_idx_q +: 8] <= byte_in_TDATA;
                        end
                        if (byte_in_TLAST) begin
                            byte_idx_q <= '0;
                            if (byte_idx_q != LAST_IDX) begin
                                err_q <= err_inc(err_q);
                            end
                        end else if (byte_idx_q == LAST_IDX) begin
                            state_q    <= DISCARD;
                            byte_idx_q <= '0;
                            err_q      <= err_inc(err_q);
                        end else begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                        end
                    end
                    DISCARD: begin
                        if (byte_in_TLAST) begin
                            state_q <= ASSEMBLE;
                        end
                    end
                    default: state_q <= ASSEMBLE;
                endcase
            end else if (timeout) begin
                byte_idx_q <= '0;
                err_q      <= err_inc(err_q);
            end
        end
    end

    dbg_cmd_fifo #(
        .WIDTH (CMD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({byte_in_TDATA, shift_q}),
        .full_o      (fifo_full),
        .pop_i       (cmd_out_TREADY),
        .empty_o     (fifo_empty),
        .head_o      (cmd_out_TDATA),
        .level_o     (fifo_level)
    );

endmodule

// File: tb/tb_dbg_cmd_assembler.sv
// Directed bench for dbg_cmd_assembler: per-cycle vector table plus multi-cycle sequences.
module tb_dbg_cmd_assembler;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byte_in_TDATA = '0;
    logic        byte_in_TVALID = 1'b0;
    logic        byte_in_TLAST = 1'b0;
    logic        byte_in_TREADY;
    logic [31:0] cmd_out_TDATA;
    logic        cmd_out_TVALID;
    logic        cmd_out_TREADY = 1'b0;
    logic [7:0]  err_count;
    logic [2:0]  fifo_level;

    int total = 0;
    int bad   = 0;

    logic [31:0] got[$];
    logic [31:0] exp_q[$];

    typedef struct {
        logic [7:0]  data;
        logic        valid;
        logic        last;
        logic        cmd_rdy;
        logic        exp_rdy;
        logic        exp_vld;
        logic [31:0] exp_dat;
        logic [7:0]  exp_err;
        logic [2:0]  exp_lvl;
    } vec_t;

    vec_t vecs[$];

    dbg_cmd_assembler #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .byte_in_TDATA  (byte_in_TDATA),
        .byte_in_TVALID (byte_in_TVALID),
        .byte_in_TLAST  (byte_in_TLAST),
        .byte_in_TREADY (byte_in_TREADY),
        .cmd_out_TDATA  (cmd_out_TDATA),
        .cmd_out_TVALID (cmd_out_TVALID),
        .cmd_out_TREADY (cmd_out_TREADY),
        .err_count      (err_count),
        .fifo_level     (fifo_level)
    );

    always #5 clk = ~clk;

    // Records every word the governor side would accept on the following rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && cmd_out_TVALID && cmd_out_TREADY) got.push_back(cmd_out_TDATA);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [7:0] d, input logic v, input logic l,
                                input logic cr, input logic er, input logic ev,
                                input logic [31:0] ed, input logic [7:0] ee,
                                input logic [2:0] el);
        vec_t r;
        r.data = d; r.valid = v; r.last = l; r.cmd_rdy = cr;
        r.exp_rdy = er; r.exp_vld = ev; r.exp_dat = ed; r.exp_err = ee; r.exp_lvl = el;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic v, input logic l);
        byte_in_TDATA  = d;
        byte_in_TVALID = v;
        byte_in_TLAST  = l;
    endtask

    // Called at a falling edge with a byte driven; returns at a falling edge after acceptance.
    task automatic wait_accept();
        int n = 0;
        while (!byte_in_TREADY && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!byte_in_TREADY) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got TREADY=0 for %0d cycles expected acceptance", n);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        byte_in_TVALID = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        drive(d, 1'b1, l);
        wait_accept();
    endtask

    task automatic send_frame(input logic [31:0] w);
        send_byte(w[7:0], 1'b0);
        send_byte(w[15:8], 1'b0);
        send_byte(w[23:16], 1'b0);
        send_byte(w[31:24], 1'b1);
    endtask

    task automatic idle(input int n);
        byte_in_TVALID = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_words(input string name);
        chk({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("%s_word%0d", name, i), got[i], exp_q[i]);
        end
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset values while reset is held.
        #1;
        chk("rst_tready", 32'(byte_in_TREADY), 0);
        chk("rst_tvalid", 32'(cmd_out_TVALID), 0);
        chk("rst_tdata", cmd_out_TDATA, 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_level", 32'(fifo_level), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmd_out_TREADY = 1'b1;
        @(negedge clk);
        chk("post_rst_tready", 32'(byte_in_TREADY), 1);

        // Vector table: inputs for one cycle, outputs expected after that rising edge.
        vecs.push_back(mk(8'h78, 1, 0, 1, 1, 0, 32'h0, 8'd0, 3'd0));
        vecs.push_back(mk(8'h56, 1, 0, 1, 1, 0, 32'h0, 8'd0, 3'd0));
        vecs.push_back(mk(8'h34, 1, 0, 1, 1, 0, 32'h0, 8'd0, 3'd0));
        vecs.push_back(mk(8'h12, 1, 1, 1, 1, 1, 32'h12345678, 8'd0, 3'd1));
        vecs.push_back(mk(8'h00, 0, 0, 1, 1, 0, 32'h0, 8'd0, 3'd0));
        vecs.push_back(mk(8'h01, 1, 0, 1, 1, 0, 32'h0, 8'd0, 3'd0));
        vecs.push_back(mk(8'h02, 1, 1, 1, 1, 0, 32'h0, 8'd1, 3'd0));
        vecs.push_back(mk(8'hAA, 1, 0, 1, 1, 0, 32'h0, 8'd1, 3'd0));
        vecs.push_back(mk(8'hBB, 1, 0, 1, 1, 0, 32'h0, 8'd1, 3'd0));
        vecs.push_back(mk(8'hCC, 1, 0, 1, 1, 0, 32'h0, 8'd1, 3'd0));
        vecs.push_back(mk(8'hDD, 1, 1, 1, 1, 1, 32'hDDCCBBAA, 8'd1, 3'd1));
        vecs.push_back(mk(8'h00, 0, 0, 1, 1, 0, 32'h0, 8'd1, 3'd0));
        vecs.push_back(mk(8'h10, 1, 0, 1, 1, 0, 32'h0, 8'd1, 3'd0));
        vecs.push_back(mk(8'h11, 1, 0, 1, 1, 0, 32'h0, 8'd1, 3'd0));
        vecs.push_back(mk(8'h12, 1, 0, 1, 1, 0, 32'h0, 8'd1, 3'd0));
        vecs.push_back(mk(8'h13, 1, 0, 1, 1, 0, 32'h0, 8'd2, 3'd0));
        vecs.push_back(mk(8'h14, 1, 0, 1, 1, 0, 32'h0, 8'd2, 3'd0));
        vecs.push_back(mk(8'h15, 1, 1, 1, 1, 0, 32'h0, 8'd2, 3'd0));
        vecs.push_back(mk(8'h01, 1, 0, 1, 1, 0, 32'h0, 8'd2, 3'd0));
        vecs.push_back(mk(8'h02, 1, 0, 1, 1, 0, 32'h0, 8'd2, 3'd0));
        vecs.push_back(mk(8'h03, 1, 0, 1, 1, 0, 32'h0, 8'd2, 3'd0));
        vecs.push_back(mk(8'h04, 1, 1, 1, 1, 1, 32'h04030201, 8'd2, 3'd1));
        vecs.push_back(mk(8'h00, 0, 0, 1, 1, 0, 32'h0, 8'd2, 3'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].data, vecs[i].valid, vecs[i].last);
            cmd_out_TREADY = vecs[i].cmd_rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_tready", i), 32'(byte_in_TREADY), 32'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d_tvalid", i), 32'(cmd_out_TVALID), 32'(vecs[i].exp_vld));
            chk($sformatf("vec%0d_err", i), 32'(err_count), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].exp_lvl));
            if (vecs[i].exp_vld) begin
                chk($sformatf("vec%0d_tdata", i), cmd_out_TDATA, vecs[i].exp_dat);
            end
        end
        byte_in_TVALID = 1'b0;
        idle(2);
        exp_q = '{32'h12345678, 32'hDDCCBBAA, 32'h04030201};
        check_words("framing");

        // Back-pressure: fill the FIFO, stall the fifth frame's last byte, then drain.
        cmd_out_TREADY = 1'b0;
        for (int k = 0; k < 4; k++) send_frame(32'hC3B2A100 | 32'(k));
        chk("full_level", 32'(fifo_level), 4);
        chk("full_head", cmd_out_TDATA, 32'hC3B2A100);
        send_byte(8'h04, 1'b0);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hB2, 1'b0);
        drive(8'hC3, 1'b1, 1'b1);
        chk("stall_tready", 32'(byte_in_TREADY), 0);
        repeat (3) @(negedge clk);
        chk("stall_tready_held", 32'(byte_in_TREADY), 0);
        chk("stall_level", 32'(fifo_level), 4);
        chk("stall_head_stable", cmd_out_TDATA, 32'hC3B2A100);
        cmd_out_TREADY = 1'b1;
        wait_accept();
        idle(8);
        chk("drain_level", 32'(fifo_level), 0);
        for (int k = 0; k < 5; k++) exp_q.push_back(32'hC3B2A100 | 32'(k));
        check_words("backpressure");

        // Reset in mid-frame with a word still buffered.
        cmd_out_TREADY = 1'b0;
        send_frame(32'hDEADBEEF);
        send_byte(8'h99, 1'b0);
        send_byte(8'h98, 1'b0);
        chk("pre_rst_level", 32'(fifo_level), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tready", 32'(byte_in_TREADY), 0);
        chk("mid_rst_tvalid", 32'(cmd_out_TVALID), 0);
        chk("mid_rst_tdata", cmd_out_TDATA, 0);
        chk("mid_rst_err", 32'(err_count), 0);
        chk("mid_rst_level", 32'(fifo_level), 0);
        @(negedge clk);
        rst = 1'b0;
        cmd_out_TREADY = 1'b1;
        got.delete();
        @(negedge clk);
        chk("mid_rst_release_tready", 32'(byte_in_TREADY), 1);
        send_frame(32'h44332211);
        idle(6);
        chk("after_rst_err", 32'(err_count), 0);
        exp_q = '{32'h44332211};
        check_words("reset");

        // One dangling byte, 16 idle cycles, then a full frame.
        send_byte(8'hEE, 1'b0);
        idle(16);
        chk("dangle_tready", 32'(byte_in_TREADY), 1);
        chk("dangle_level", 32'(fifo_level), 0);
        send_frame(32'h11223344);
        idle(6);
        chk("dangle_err", 32'(err_count), 1);
`ifdef DBG_CMD_TIMEOUT_EN
        exp_q = '{32'h11223344};
        check_words("timeout");
`else
        // Held byte shifts the frame: EE,44,33,22 is a long frame and 11 closes the discard.
        check_words("no_timeout");
        send_frame(32'h04030201);
        idle(6);
        chk("recover_err", 32'(err_count), 1);
        exp_q = '{32'h04030201};
        check_words("recover");
`endif

        // Error counter saturation via single-byte short frames.
        for (int i = 0; i < 260; i++) send_byte(8'h55, 1'b1);
        idle(2);
        chk("err_saturate", 32'(err_count), 32'hFF);
        chk("err_saturate_level", 32'(fifo_level), 0);
        send_frame(32'hCAFEF00D);
        idle(6);
        chk("err_saturate_hold", 32'(err_count), 32'hFF);
        exp_q = '{32'hCAFEF00D};
        check_words("after_sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
